// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun,
        StMduWait,
        StHalt
    } state_e;

    localparam int unsigned RegZero       = 0;
    localparam int unsigned MduLatDefault = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Status inputs from the pipeline stages and control outputs back to the stage registers.
interface pipe_hazard_ctrl_if #(
    parameter int unsigned W_BITS = 6,
    parameter int unsigned CNT_W  = 32
);
    logic [W_BITS-1:0] id_rs;
    logic [W_BITS-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              ex_ld;
    logic [W_BITS-1:0] ex_write;
    logic              ex_mdu;
    logic              ex_br_taken;
    logic              wb_syscall;
    logic              wb_halt;
    logic              resume;

    logic              if_en;
    logic              id_en;
    logic              ex_en;
    logic              mem_en;
    logic              wb_en;
    logic              if_id_zero;
    logic              id_ex_zero;
    logic              ex_mem_zero;
    logic              mem_wb_zero;
    logic              mdu_go;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Pipeline side: reports stage status, consumes enables and clears.
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_ld, ex_write, ex_mdu, ex_br_taken,
        output wb_syscall, wb_halt, resume,
        input  if_en, id_en, ex_en, mem_en, wb_en,
        input  if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero,
        input  mdu_go, halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_ld, ex_write, ex_mdu, ex_br_taken,
        input  wb_syscall, wb_halt, resume,
        output if_en, id_en, ex_en, mem_en, wb_en,
        output if_id_zero, id_ex_zero, ex_mem_zero, mem_wb_zero,
        output mdu_go, halted, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// Combinational RAW compare of two source operands against one in-flight destination.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W_BITS = 6
) (
    input  logic [W_BITS-1:0] src_a_i,
    input  logic [W_BITS-1:0] src_b_i,
    input  logic              use_a_i,
    input  logic              use_b_i,
    input  logic [W_BITS-1:0] dst_i,
    input  logic              dst_vld_i,
    output logic              hit_o
);

    logic dst_live;

    // Writes to the zero register are discarded, so they can never feed a consumer.
    assign dst_live = dst_vld_i & (dst_i != W_BITS'(RegZero));

    assign hit_o = dst_live & ((use_a_i & (src_a_i == dst_i)) |
                               (use_b_i & (src_b_i == dst_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: load-use stalls, branch flushes, MDU occupancy, syscall halt.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W_BITS  = 6,
    parameter int unsigned MDU_LAT = MduLatDefault,
    parameter int unsigned CNT_W   = 32
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int unsigned MduCntW = 4;

    state_e             state_q, state_d;
    logic [MduCntW-1:0] mdu_cnt_q, mdu_cnt_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;

    logic load_use;
    logic halt_req;
    logic stall_inc;
    logic flush_inc;
    logic if_en, id_en, ex_en, mem_en, wb_en;
    logic if_id_zero, id_ex_zero, ex_mem_zero;
    logic mdu_go, halted;

    hazard_detect #(
        .W_BITS (W_BITS)
    ) u_load_use (
        .src_a_i   (bus.id_rs),
        .src_b_i   (bus.id_rt),
        .use_a_i   (bus.id_use_rs),
        .use_b_i   (bus.id_use_rt),
        .dst_i     (bus.ex_write),
        .dst_vld_i (bus.ex_ld),
        .hit_o     (load_use)
    );

    assign halt_req = bus.wb_syscall & bus.wb_halt;

    always_comb begin
        state_d     = state_q;
        mdu_cnt_d   = mdu_cnt_q;
        done_d      = done_q;
        if_en       = 1'b1;
        id_en       = 1'b1;
        ex_en       = 1'b1;
        mem_en      = 1'b1;
        wb_en       = 1'b1;
        if_id_zero  = 1'b0;
        id_ex_zero  = 1'b0;
        ex_mem_zero = 1'b0;
        mdu_go      = 1'b0;
        halted      = 1'b0;
        flush_inc   = 1'b0;

        unique case (state_q)
            StRun: begin
                done_d = 1'b0;
                if (halt_req) begin
                    {if_en, id_en, ex_en, mem_en, wb_en} = '0;
                    state_d = StHalt;
                end else if (bus.ex_mdu && !done_q) begin
                    {if_en, id_en, ex_en} = '0;
                    ex_mem_zero = 1'b1;
                    mdu_go      = 1'b1;
                    mdu_cnt_d   = MduCntW'(MDU_LAT - 1);
                    state_d     = StMduWait;
                end else if (bus.ex_br_taken) begin
                    // The ID instruction is squashed, so a load-use match there is moot.
                    if_id_zero = 1'b1;
                    id_ex_zero = 1'b1;
                    flush_inc  = 1'b1;
                end else if (load_use) begin
                    if_en      = 1'b0;
                    id_en      = 1'b0;
                    id_ex_zero = 1'b1;
                end
            end
            StMduWait: begin
                if (halt_req) begin
                    {if_en, id_en, ex_en, mem_en, wb_en} = '0;
                    state_d = StHalt;
                end else begin
                    {if_en, id_en, ex_en} = '0;
                    ex_mem_zero = 1'b1;
                    mdu_cnt_d   = mdu_cnt_q - 1'b1;
                    if (mdu_cnt_q == MduCntW'(1)) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                    end
                end
            end
            StHalt: begin
                {if_en, id_en, ex_en, mem_en, wb_en} = '0;
                halted = 1'b1;
                if (bus.resume) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    assign stall_inc = ~if_en & (state_q != StHalt);

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (stall_inc && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
        if (flush_inc && (flush_q != '1)) begin
            flush_d = flush_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StRun;
            mdu_cnt_q <= '0;
            done_q    <= 1'b0;
            stall_q   <= '0;
            flush_q   <= '0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
            done_q    <= done_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
        end
    end

    assign bus.if_en       = if_en;
    assign bus.id_en       = id_en;
    assign bus.ex_en       = ex_en;
    assign bus.mem_en      = mem_en;
    assign bus.wb_en       = wb_en;
    assign bus.if_id_zero  = if_id_zero;
    assign bus.id_ex_zero  = id_ex_zero;
    assign bus.ex_mem_zero = ex_mem_zero;
    assign bus.mem_wb_zero = 1'b0;
    assign bus.mdu_go      = mdu_go;
    assign bus.halted      = halted;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a per-cycle reference model and literal spot checks.
module tb_pipe_hazard_ctrl;

    localparam int unsigned WB   = 6;
    localparam int unsigned LAT  = 4;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.W_BITS(WB), .CNT_W(CW)) bus ();

    pipe_hazard_ctrl #(
        .W_BITS  (WB),
        .MDU_LAT (LAT),
        .CNT_W   (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Model: pipeline mode as "frozen", "MDU cycles still owed", "MDU just finished".
    bit m_halt;
    int m_wait;
    bit m_done;
    int m_stall;
    int m_flush;

    bit e_if, e_id, e_ex, e_mem, e_wb, e_ifz, e_idz, e_exz, e_go, e_hlt;
    bit stall_cyc, flush_cyc, hz;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_halt  = 1'b0;
            m_wait  = 0;
            m_done  = 1'b0;
            m_stall = 0;
            m_flush = 0;
        end
        {e_if, e_id, e_ex, e_mem, e_wb} = 5'b11111;
        {e_ifz, e_idz, e_exz, e_go, e_hlt} = 5'b00000;
        stall_cyc = 1'b0;
        flush_cyc = 1'b0;
        hz = bus.ex_ld && (bus.ex_write != 0) &&
             ((bus.id_use_rs && (bus.id_rs == bus.ex_write)) ||
              (bus.id_use_rt && (bus.id_rt == bus.ex_write)));
        if (m_halt) begin
            {e_if, e_id, e_ex, e_mem, e_wb} = 5'b00000;
            e_hlt = 1'b1;
        end else if (bus.wb_syscall && bus.wb_halt) begin
            {e_if, e_id, e_ex, e_mem, e_wb} = 5'b00000;
            stall_cyc = 1'b1;
        end else if ((m_wait > 0) || (bus.ex_mdu && !m_done)) begin
            {e_if, e_id, e_ex} = 3'b000;
            e_exz     = 1'b1;
            e_go      = (m_wait == 0);
            stall_cyc = 1'b1;
        end else if (bus.ex_br_taken) begin
            e_ifz     = 1'b1;
            e_idz     = 1'b1;
            flush_cyc = 1'b1;
        end else if (hz) begin
            e_if      = 1'b0;
            e_id      = 1'b0;
            e_idz     = 1'b1;
            stall_cyc = 1'b1;
        end

        cmp("if_en", int'(bus.if_en), int'(e_if));
        cmp("id_en", int'(bus.id_en), int'(e_id));
        cmp("ex_en", int'(bus.ex_en), int'(e_ex));
        cmp("mem_en", int'(bus.mem_en), int'(e_mem));
        cmp("wb_en", int'(bus.wb_en), int'(e_wb));
        cmp("if_id_zero", int'(bus.if_id_zero), int'(e_ifz));
        cmp("id_ex_zero", int'(bus.id_ex_zero), int'(e_idz));
        cmp("ex_mem_zero", int'(bus.ex_mem_zero), int'(e_exz));
        cmp("mem_wb_zero", int'(bus.mem_wb_zero), 0);
        cmp("mdu_go", int'(bus.mdu_go), int'(e_go));
        cmp("halted", int'(bus.halted), int'(e_hlt));
        cmp("stall_cnt", int'(bus.stall_cnt), m_stall);
        cmp("flush_cnt", int'(bus.flush_cnt), m_flush);

        if (rst_n) begin
            if (m_halt) begin
                if (bus.resume) m_halt = 1'b0;
            end else if (bus.wb_syscall && bus.wb_halt) begin
                m_halt = 1'b1;
                m_wait = 0;
                m_done = 1'b0;
            end else if (m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_done = 1'b1;
            end else if (bus.ex_mdu && !m_done) begin
                m_wait = LAT - 1;
            end else begin
                m_done = 1'b0;
            end
            if (stall_cyc && (m_stall < CMAX)) m_stall++;
            if (flush_cyc && (m_flush < CMAX)) m_flush++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(bus.ex_mdu && bus.ex_br_taken))
            else $error("illegal: ex_mdu and ex_br_taken together");
        end
    end

    task automatic idle();
        bus.id_rs       = '0;
        bus.id_rt       = '0;
        bus.id_use_rs   = 1'b0;
        bus.id_use_rt   = 1'b0;
        bus.ex_ld       = 1'b0;
        bus.ex_write    = '0;
        bus.ex_mdu      = 1'b0;
        bus.ex_br_taken = 1'b0;
        bus.wb_syscall  = 1'b0;
        bus.wb_halt     = 1'b0;
        bus.resume      = 1'b0;
    endtask

    task automatic load_use(input int rs, input int wr);
        bus.ex_ld     = 1'b1;
        bus.ex_write  = WB'(wr);
        bus.id_rs     = WB'(rs);
        bus.id_use_rs = 1'b1;
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int go_n, low_n, exz_n, frz_n;

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        cyc(); cyc(); #2;
        cmp("idle if_en", int'(bus.if_en), 1);
        cmp("idle stall_cnt", int'(bus.stall_cnt), 0);
        cmp("idle flush_cnt", int'(bus.flush_cnt), 0);

        // Single load-use stall on rs
        cyc(); load_use(8, 8); #2;
        cmp("lu if_en", int'(bus.if_en), 0);
        cmp("lu id_ex_zero", int'(bus.id_ex_zero), 1);
        cyc(); idle(); #2;
        cmp("lu released if_en", int'(bus.if_en), 1);
        cmp("lu stall_cnt", int'(bus.stall_cnt), 1);

        // Load into r0 never stalls
        cyc(); load_use(0, 0); #2;
        cmp("r0 if_en", int'(bus.if_en), 1);
        // rt-only match
        cyc(); idle(); bus.ex_ld = 1'b1; bus.ex_write = WB'(5);
        bus.id_rt = WB'(5); bus.id_use_rt = 1'b1; bus.id_rs = WB'(5);
        cyc(); bus.id_use_rt = 1'b0;
        cyc(); idle();

        // MDU occupancy with ex_mdu held through the done cycle
        cyc(); rst_n = 1'b0;
        cyc(); rst_n = 1'b1;
        cyc(); bus.ex_mdu = 1'b1;
        go_n = 0; low_n = 0; exz_n = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            go_n  += int'(bus.mdu_go);
            low_n += int'(!bus.if_en);
            exz_n += int'(bus.ex_mem_zero);
            if (i == 4) cmp("mdu done ex_en", int'(bus.ex_en), 1);
            cyc();
        end
        bus.ex_mdu = 1'b0;
        cmp("mdu_go pulses", go_n, 1);
        cmp("mdu if_en low cycles", low_n, 4);
        cmp("mdu ex_mem_zero cycles", exz_n, 4);
        #2 cmp("mdu stall_cnt", int'(bus.stall_cnt), 4);

        // Reset in the middle of MDU_WAIT
        cyc(); bus.ex_mdu = 1'b1;
        cyc(); cyc();
        rst_n = 1'b0; idle(); #2;
        cmp("rst mid-mdu if_en", int'(bus.if_en), 1);
        cmp("rst mid-mdu ex_mem_zero", int'(bus.ex_mem_zero), 0);
        cyc(); rst_n = 1'b1;
        cyc(); #2;
        cmp("post rst ex_en", int'(bus.ex_en), 1);
        cmp("post rst stall_cnt", int'(bus.stall_cnt), 0);

        // Branch overrides load-use
        cyc(); load_use(8, 8); bus.ex_br_taken = 1'b1; #2;
        cmp("br if_id_zero", int'(bus.if_id_zero), 1);
        cmp("br id_ex_zero", int'(bus.id_ex_zero), 1);
        cmp("br if_en", int'(bus.if_en), 1);
        cyc(); idle(); #2;
        cmp("br flush_cnt", int'(bus.flush_cnt), 1);
        cmp("br stall_cnt", int'(bus.stall_cnt), 0);

        // Halt raised during MDU_WAIT, then ten frozen cycles and a resume
        cyc(); bus.ex_mdu = 1'b1;
        cyc(); bus.wb_syscall = 1'b1; bus.wb_halt = 1'b1; #2;
        cmp("halt entry wb_en", int'(bus.wb_en), 0);
        cmp("halt entry halted", int'(bus.halted), 0);
        cyc(); bus.wb_syscall = 1'b0; bus.wb_halt = 1'b0;
        frz_n = 0;
        for (int i = 0; i < 10; i++) begin
            #2;
            frz_n += int'(bus.halted && !bus.if_en && !bus.ex_en && !bus.wb_en);
            cyc();
        end
        cmp("halt frozen cycles", frz_n, 10);
        bus.ex_mdu = 1'b0; bus.resume = 1'b1; #2;
        cmp("resume cycle halted", int'(bus.halted), 1);
        cyc(); bus.resume = 1'b0; #2;
        cmp("after resume halted", int'(bus.halted), 0);
        cmp("after resume if_en", int'(bus.if_en), 1);
        cmp("halt stall_cnt", int'(bus.stall_cnt), 2);

        // Counter saturation: 2^CW+3 flushes, then a long load-use hold
        for (int i = 0; i < (1 << CW) + 3; i++) begin
            cyc(); bus.ex_br_taken = 1'b1;
        end
        cyc(); idle(); #2;
        cmp("flush_cnt saturated", int'(bus.flush_cnt), 15);
        cyc(); load_use(3, 3);
        repeat (20) cyc();
        idle(); #2;
        cmp("stall_cnt saturated", int'(bus.stall_cnt), 15);

        cyc(); cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
